// File: rtl/fetch_decode_pkg.sv
// Shared definitions for the fetch/decode unit: FSM encoding, instruction field
// positions, compare opcodes and branch-offset helper.
package fetch_decode_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fd_state_e;

  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int OPC_LSB   = 21;
  localparam int IMM_BIT   = 25;
  localparam int OP2_LSB   = 0;
  localparam int CLASS_LSB = 25;
  localparam int DP_LSB    = 26;
  localparam int OFF_MSB   = 23;

  localparam logic [3:0] OPC_TST = 4'b1000;
  localparam logic [3:0] OPC_TEQ = 4'b1001;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_CMN = 4'b1011;

  localparam logic [2:0] BRANCH_CLASS = 3'b101;
  localparam logic [1:0] DP_CLASS     = 2'b00;

  // Signed word offset of a branch, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [31:0] ir);
    return {{6{ir[OFF_MSB]}}, ir[OFF_MSB:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_unit_decoder.sv
// Combinational field extraction and classification of the held instruction.
// The condition field and S bit are not used by this unit.
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  addr_a,
  output logic [3:0]  addr_b,
  output logic [3:0]  opcode,
  output logic        imm_flag,
  output logic [11:0] operand2,
  output logic        is_branch,
  output logic        writes_reg
);

  logic is_dp;
  logic is_compare;
  logic unused_ir;

  assign addr_a    = ir[RN_LSB +: 4];
  assign addr_b    = ir[RD_LSB +: 4];
  assign opcode    = ir[OPC_LSB +: 4];
  assign imm_flag  = ir[IMM_BIT];
  assign operand2  = ir[OP2_LSB +: 12];
  assign is_branch = (ir[CLASS_LSB +: 3] == BRANCH_CLASS);

  assign is_dp      = (ir[DP_LSB +: 2] == DP_CLASS);
  assign is_compare = (opcode inside {OPC_TST, OPC_TEQ, OPC_CMP, OPC_CMN});
  assign writes_reg = is_dp && !is_compare;

  assign unused_ir = ^{ir[31:28], ir[20]};

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch over req/ack, instruction register, PC stepping and issue
// handshake towards execute; decode is delegated to instr_decoder.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_FETCH  | request instruction at pc (unless halted or just reset)
// ST_WAIT   | request outstanding, hold address until ack
// ST_ISSUE  | decoded instruction presented until execute accepts
// ST_HALTED | no fetch until halt_in drops
module fetch_decode_unit
  import fetch_decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_AHEAD = 32'd8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  input  logic        halt_in,
  output logic        issue_valid_out,
  input  logic        exec_ready_in,
  output logic [3:0]  addr_portA_out,
  output logic [3:0]  addr_portB_out,
  output logic        write_en_out,
  output logic [31:0] pc_r15_out,
  output logic [3:0]  opcode_out,
  output logic        imm_flag_out,
  output logic [11:0] operand2_out,
  output logic        is_branch_out
);

  fd_state_e   state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        req_blank;
  logic        writes_reg;

  instr_decoder u_decoder (
    .ir         (ir),
    .addr_a     (addr_portA_out),
    .addr_b     (addr_portB_out),
    .opcode     (opcode_out),
    .imm_flag   (imm_flag_out),
    .operand2   (operand2_out),
    .is_branch  (is_branch_out),
    .writes_reg (writes_reg)
  );

  // req_blank keeps the cycle after reset request-free, so a stale ack from a
  // request dropped by reset is never taken as a new instruction.
  assign imem_req_out    = !req_blank &&
                           (((state == ST_FETCH) && !halt_in) || (state == ST_WAIT));
  assign imem_addr_out   = pc;
  assign issue_valid_out = (state == ST_ISSUE);
  assign write_en_out    = issue_valid_out && writes_reg;
  assign pc_r15_out      = pc + PC_AHEAD;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      req_blank <= 1'b1;
    end else begin
      req_blank <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (!req_blank) begin
            if (halt_in) begin
              state <= ST_HALTED;
            end else if (imem_ack_in) begin
              ir    <= imem_data_in;
              state <= ST_ISSUE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_ack_in) begin
            ir    <= imem_data_in;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (exec_ready_in) begin
            pc    <= is_branch_out ? (pc + PC_AHEAD + branch_offset(ir)) : (pc + 32'd4);
            state <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (!halt_in) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
